// File: rtl/bids22_round_sequencer_pkg.sv
// Round sequencer FSM encoding and load-step constants.
// The UNLK state exists only when BIDS22_SEQ_AUTOUNLOCK_EN is defined.
package bids22_round_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT,
    S_DRAIN,
`ifdef BIDS22_SEQ_AUTOUNLOCK_EN
    S_UNLK,
`endif
    S_DONE
  } seq_state_t;

  // Steps 0..6 drive the seven load opcodes; step 7 only checks LOCK's error.
  localparam logic [2:0] LAST_STEP = 3'd7;

endpackage

// File: rtl/bids22defs.sv
// Shared auction definitions: control opcodes, error codes, data width and the
// round-sequencer result status.
package bids22defs;

  localparam int DATAWIDTH = 32;

  typedef enum logic [3:0] {
    NO_OP        = 4'd0,
    LOADX        = 4'd1,
    LOADY        = 4'd2,
    LOADZ        = 4'd3,
    SETMASK      = 4'd4,
    SETTIMER     = 4'd5,
    SETBIDCHARGE = 4'd6,
    LOCK         = 4'd7,
    UNLOCK       = 4'd8
  } opcode_t;

  typedef enum logic [1:0] {
    NOERROR    = 2'd0,
    BIDLOW     = 2'd1,
    INVALID_OP = 2'd2,
    BADKEY     = 2'd3
  } error_t;

  typedef enum logic [1:0] {
    SEQ_OK      = 2'd0,
    SEQ_DUTERR  = 2'd1,
    SEQ_TIMEOUT = 2'd2
  } seq_status_t;

endpackage

// File: rtl/bids22_round_sequencer_if.sv
// Host command/result port of the round sequencer.
// Handshake: a command transfers on a rising edge where cfg_valid && cfg_ready;
// res_valid is a one-cycle pulse with no backpressure.
interface bids22_round_sequencer_if #(
  parameter int DATAWIDTH  = 32,
  parameter int NUMBIDDERS = 3
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DATAWIDTH-1:0]  cfg_x;
  logic [DATAWIDTH-1:0]  cfg_y;
  logic [DATAWIDTH-1:0]  cfg_z;
  logic [NUMBIDDERS-1:0] cfg_mask;
  logic [DATAWIDTH-1:0]  cfg_timer;
  logic [DATAWIDTH-1:0]  cfg_bidcharge;
  logic [DATAWIDTH-1:0]  cfg_key;
  logic [15:0]           cfg_roundlen;
  logic                  res_valid;
  logic [DATAWIDTH-1:0]  res_maxbid;
  logic [1:0]            res_status;

  modport master (
    output cfg_valid, cfg_x, cfg_y, cfg_z, cfg_mask, cfg_timer, cfg_bidcharge,
           cfg_key, cfg_roundlen,
    input  cfg_ready, res_valid, res_maxbid, res_status
  );

  modport slave (
    input  cfg_valid, cfg_x, cfg_y, cfg_z, cfg_mask, cfg_timer, cfg_bidcharge,
           cfg_key, cfg_roundlen,
    output cfg_ready, res_valid, res_maxbid, res_status
  );
endinterface

// File: rtl/bids22_round_sequencer.sv
// Loads, runs and closes one bids22 auction round per host command.
// Define BIDS22_SEQ_AUTOUNLOCK_EN to issue UNLOCK/key before the result.
module bids22_round_sequencer #(
  parameter int DATAWIDTH  = 32,
  parameter int NUMBIDDERS = 3,
  parameter int TIMEOUT    = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  bids22_round_sequencer_if.slave  host,
  output bids22defs::opcode_t      C_op,
  output logic [DATAWIDTH-1:0]     C_data,
  output logic                     C_start,
  input  logic                     dut_ready,
  input  bids22defs::error_t       dut_err,
  input  logic [DATAWIDTH-1:0]     dut_maxbid,
  output logic [2:0]               dbg_state_o
);
  import bids22defs::*;
  import bids22_round_sequencer_pkg::*;

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] LAST_WAIT = WCW'(TIMEOUT - 1);

  seq_state_t            state_q, state_d;
  logic [2:0]            step_q, step_d;
  logic [15:0]           run_cnt_q, run_cnt_d;
  logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [DATAWIDTH-1:0]  x_q, y_q, z_q, timer_q, charge_q, key_q;
  logic [NUMBIDDERS-1:0] mask_q;

  opcode_t               c_op_q, c_op_d;
  logic [DATAWIDTH-1:0]  c_data_q, c_data_d;
  logic                  c_start_q, c_start_d;
  logic                  cfg_ready_q, cfg_ready_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATAWIDTH-1:0]  res_maxbid_q, res_maxbid_d;
  seq_status_t           res_status_q, res_status_d;

  logic accept;
  logic load_err;

  assign accept   = host.cfg_valid && cfg_ready_q;
  // The error seen now belongs to the opcode issued on the previous step.
  assign load_err = (state_q == S_LOAD) && (step_q != 3'd0) && (dut_err != NOERROR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      run_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      mask_q       <= '0;
      timer_q      <= '0;
      charge_q     <= '0;
      key_q        <= '0;
      c_op_q       <= NO_OP;
      c_data_q     <= '0;
      c_start_q    <= 1'b0;
      cfg_ready_q  <= 1'b1;
      res_valid_q  <= 1'b0;
      res_maxbid_q <= '0;
      res_status_q <= SEQ_OK;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      run_cnt_q    <= run_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      c_op_q       <= c_op_d;
      c_data_q     <= c_data_d;
      c_start_q    <= c_start_d;
      cfg_ready_q  <= cfg_ready_d;
      res_valid_q  <= res_valid_d;
      res_maxbid_q <= res_maxbid_d;
      res_status_q <= res_status_d;
      if (accept) begin
        x_q      <= host.cfg_x;
        y_q      <= host.cfg_y;
        z_q      <= host.cfg_z;
        mask_q   <= host.cfg_mask;
        timer_q  <= host.cfg_timer;
        charge_q <= host.cfg_bidcharge;
        key_q    <= host.cfg_key;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    run_cnt_d  = run_cnt_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_LOAD;
          step_d    = 3'd0;
          run_cnt_d = (host.cfg_roundlen == 16'd0) ? 16'd1 : host.cfg_roundlen;
        end
      end
      S_LOAD: begin
        if (load_err)                state_d = S_DONE;
        else if (step_q == LAST_STEP) state_d = S_RUN;
        else                         step_d  = step_q + 3'd1;
      end
      S_RUN: begin
        if (run_cnt_q == 16'd1) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt_q - 16'd1;
        end
      end
      S_WAIT: begin
        if (!dut_ready)                    state_d = S_DRAIN;
        else if (wait_cnt_q == LAST_WAIT)  state_d = S_DONE;
        else                               wait_cnt_d = wait_cnt_q + 1'b1;
      end
      S_DRAIN: begin
`ifdef BIDS22_SEQ_AUTOUNLOCK_EN
        if (dut_ready) state_d = S_UNLK;
`else
        if (dut_ready) state_d = S_DONE;
`endif
      end
`ifdef BIDS22_SEQ_AUTOUNLOCK_EN
      S_UNLK:  state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    c_op_d       = NO_OP;
    c_data_d     = '0;
    c_start_d    = (state_d == S_RUN);
    cfg_ready_d  = (state_d == S_IDLE);
    res_valid_d  = (state_d == S_DONE);
    res_maxbid_d = res_maxbid_q;
    res_status_d = res_status_q;
    if (accept) begin
      res_maxbid_d = '0;
      res_status_d = SEQ_OK;
    end
    if (state_q == S_LOAD && !load_err) begin
      case (step_q)
        3'd0:    begin c_op_d = LOADX;        c_data_d = x_q;                   end
        3'd1:    begin c_op_d = LOADY;        c_data_d = y_q;                   end
        3'd2:    begin c_op_d = LOADZ;        c_data_d = z_q;                   end
        3'd3:    begin c_op_d = SETMASK;      c_data_d = DATAWIDTH'(mask_q);    end
        3'd4:    begin c_op_d = SETTIMER;     c_data_d = timer_q;               end
        3'd5:    begin c_op_d = SETBIDCHARGE; c_data_d = charge_q;              end
        3'd6:    begin c_op_d = LOCK;         c_data_d = key_q;                 end
        default: begin c_op_d = NO_OP;        c_data_d = '0;                    end
      endcase
    end
    if (load_err) begin
      res_maxbid_d = '0;
      res_status_d = SEQ_DUTERR;
    end
    if (state_q == S_WAIT) begin
      if (!dut_ready)                   res_maxbid_d = dut_maxbid;
      else if (wait_cnt_q == LAST_WAIT) res_status_d = SEQ_TIMEOUT;
    end
`ifdef BIDS22_SEQ_AUTOUNLOCK_EN
    if (state_d == S_UNLK) begin
      c_op_d   = UNLOCK;
      c_data_d = key_q;
    end
`endif
  end

  assign C_op            = c_op_q;
  assign C_data          = c_data_q;
  assign C_start         = c_start_q;
  assign host.cfg_ready  = cfg_ready_q;
  assign host.res_valid  = res_valid_q;
  assign host.res_maxbid = res_maxbid_q;
  assign host.res_status = res_status_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_bids22_round_sequencer.sv
// Directed bench for bids22_round_sequencer with a stub auction, expected
// queues for opcodes, C_start run lengths and results, and a negedge monitor.
module tb_bids22_round_sequencer;
  import bids22defs::*;

  localparam int DW   = 32;
  localparam int NB   = 3;
  localparam int TO   = 8;
  localparam int OPW  = 4 + DW;
  localparam int RESW = DW + 2 + 4 + 16;
  localparam logic [DW-1:0] GARBAGE = 32'hBAD0_BAD0;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  opcode_t       c_op;
  logic [DW-1:0] c_data;
  logic          c_start;
  logic          dut_ready = 1'b1;
  error_t        dut_err = NOERROR;
  logic [DW-1:0] dut_maxbid = '0;
  logic [2:0]    dbg_state;

  bids22_round_sequencer_if #(.DATAWIDTH(DW), .NUMBIDDERS(NB)) host ();

  bids22_round_sequencer #(.DATAWIDTH(DW), .NUMBIDDERS(NB), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .host       (host),
    .C_op       (c_op),
    .C_data     (c_data),
    .C_start    (c_start),
    .dut_ready  (dut_ready),
    .dut_err    (dut_err),
    .dut_maxbid (dut_maxbid),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [OPW-1:0]  exp_op_q[$];
  logic [15:0]     exp_run_q[$];
  logic [RESW-1:0] exp_res_q[$];
  int  checks = 0;
  int  passed = 0;
  time acc_t  = 0;

  // stub auction configuration
  int          stub_mode = 0;  // 0: ready low one cycle after C_start falls, 1: ready stuck high
  logic        err_en = 1'b0;
  opcode_t     err_op = NO_OP;
  logic [DW-1:0] stub_bid = '0;
  logic        stub_prev_start = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [OPW-1:0] mk_op(input opcode_t op, input logic [DW-1:0] d);
    return {op, d};
  endfunction

  function automatic logic [RESW-1:0] mk_res(input logic [DW-1:0] mb, input logic [1:0] st,
                                             input opcode_t prev, input int lat);
    return {mb, st, prev, 16'(lat)};
  endfunction

  // ---------------- stub auction ----------------
  always @(negedge clk) begin : stub
    if (!reset_n) begin
      dut_ready       = 1'b1;
      dut_err         = NOERROR;
      dut_maxbid      = GARBAGE;
      stub_prev_start = 1'b0;
    end else begin
      dut_err = (err_en && c_op == err_op) ? INVALID_OP : NOERROR;
      if (stub_mode == 0 && stub_prev_start && !c_start) begin
        dut_ready  = 1'b0;
        dut_maxbid = stub_bid;
      end else begin
        dut_ready  = 1'b1;
        dut_maxbid = GARBAGE;
      end
      stub_prev_start = c_start;
    end
  end

  // ---------------- monitor ----------------
  int       run_len = 0;
  opcode_t  prev_op = NO_OP;

  always @(negedge clk) begin : monitor
    logic [OPW-1:0]  eo;
    logic [RESW-1:0] er;
    logic [15:0]     erun;
    int              lat;
    if (!reset_n) begin
      run_len = 0;
      prev_op = NO_OP;
    end else begin
      if (c_op != NO_OP) begin
        if (exp_op_q.size() == 0) check("unexpected_op", {c_op, c_data}, '0);
        else begin
          eo = exp_op_q.pop_front();
          check("c_op", c_op, eo[OPW-1:DW]);
          check("c_data", c_data, eo[DW-1:0]);
        end
      end
      if (c_start) run_len++;
      else if (run_len != 0) begin
        if (exp_run_q.size() == 0) check("unexpected_run", run_len, 0);
        else begin
          erun = exp_run_q.pop_front();
          check("c_start_len", run_len, erun);
        end
        run_len = 0;
      end
      if (host.res_valid) begin
        lat = int'(($time - acc_t - 5) / 10);
        if (exp_res_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          er = exp_res_q.pop_front();
          check("res_maxbid", host.res_maxbid, er[RESW-1:22]);
          check("res_status", host.res_status, er[21:20]);
          check("op_before_result", prev_op, er[19:16]);
          check("latency", lat, er[15:0]);
        end
      end
      prev_op = c_op;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_loads(input logic [DW-1:0] x, y, z, input logic [NB-1:0] mask,
                            input logic [DW-1:0] timer, charge, key, input int n);
    logic [OPW-1:0] t[7];
    t[0] = mk_op(LOADX, x);
    t[1] = mk_op(LOADY, y);
    t[2] = mk_op(LOADZ, z);
    t[3] = mk_op(SETMASK, DW'(mask));
    t[4] = mk_op(SETTIMER, timer);
    t[5] = mk_op(SETBIDCHARGE, charge);
    t[6] = mk_op(LOCK, key);
    for (int i = 0; i < n; i++) exp_op_q.push_back(t[i]);
  endtask

  // Expected tail of a successful round: run length, optional unlock, result.
  task automatic push_ok(input int n_run, input logic [DW-1:0] bid, input logic [DW-1:0] key);
    exp_run_q.push_back(16'(n_run));
`ifdef BIDS22_SEQ_AUTOUNLOCK_EN
    exp_op_q.push_back(mk_op(UNLOCK, key));
    exp_res_q.push_back(mk_res(bid, 2'd0, UNLOCK, 11 + n_run));
`else
    exp_res_q.push_back(mk_res(bid, 2'd0, NO_OP, 10 + n_run));
    if (key == '1) $display("note: all-ones key");
`endif
  endtask

  task automatic send_cmd(input logic [DW-1:0] x, y, z, input logic [NB-1:0] mask,
                          input logic [DW-1:0] timer, charge, key, input logic [15:0] rl);
    int guard = 0;
    @(negedge clk);
    while (!host.cfg_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("cfg_ready_before_cmd", host.cfg_ready, 1);
    host.cfg_x         = x;
    host.cfg_y         = y;
    host.cfg_z         = z;
    host.cfg_mask      = mask;
    host.cfg_timer     = timer;
    host.cfg_bidcharge = charge;
    host.cfg_key       = key;
    host.cfg_roundlen  = rl;
    host.cfg_valid     = 1'b1;
    @(posedge clk);
    acc_t = $time;
    #1 host.cfg_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int guard = 0;
    while (exp_res_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check(name, exp_res_q.size(), 0);
    exp_res_q.delete();
  endtask

  task automatic wait_start();
    int guard = 0;
    while (!c_start && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("c_start_seen", c_start, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    host.cfg_valid = 1'b0;
    host.cfg_x = '0; host.cfg_y = '0; host.cfg_z = '0; host.cfg_mask = '0;
    host.cfg_timer = '0; host.cfg_bidcharge = '0; host.cfg_key = '0; host.cfg_roundlen = '0;

    repeat (3) @(negedge clk);
    check("rst_cfg_ready", host.cfg_ready, 1);
    check("rst_c_op", c_op, NO_OP);
    check("rst_c_data", c_data, 0);
    check("rst_c_start", c_start, 0);
    check("rst_res_valid", host.res_valid, 0);
    check("rst_res_maxbid", host.res_maxbid, 0);
    check("rst_res_status", host.res_status, 0);
    reset_n = 1'b1;

    // Nominal round, with cfg_valid pulsed while busy (must be ignored)
    stub_mode = 0; stub_bid = 32'd30;
    push_loads(32'd100, 32'd50, 32'd20, 3'b111, 32'd5, 32'd1, 32'hA5, 7);
    push_ok(4, 32'd30, 32'hA5);
    send_cmd(32'd100, 32'd50, 32'd20, 3'b111, 32'd5, 32'd1, 32'hA5, 16'd4);
    wait_start();
    host.cfg_x = 32'hFFFF; host.cfg_key = 32'h77; host.cfg_valid = 1'b1;
    repeat (3) @(negedge clk);
    host.cfg_valid = 1'b0;
    wait_result("result_nominal");
    repeat (2) @(negedge clk);
    check("res_maxbid_hold", host.res_maxbid, 30);

    // Round length 0 behaves as 1
    stub_bid = 32'd77;
    push_loads(32'd1, 32'd2, 32'd3, 3'b010, 32'd9, 32'd4, 32'h3C, 7);
    push_ok(1, 32'd77, 32'h3C);
    send_cmd(32'd1, 32'd2, 32'd3, 3'b010, 32'd9, 32'd4, 32'h3C, 16'd0);
    wait_result("result_rl0");

    // Auction rejects SETMASK: abort before SETTIMER
    err_en = 1'b1; err_op = SETMASK;
    push_loads(32'd11, 32'd12, 32'd13, 3'b001, 32'd14, 32'd15, 32'h16, 4);
    exp_res_q.push_back(mk_res(32'd0, 2'd1, SETMASK, 5));
    send_cmd(32'd11, 32'd12, 32'd13, 3'b001, 32'd14, 32'd15, 32'h16, 16'd3);
    wait_result("result_duterr");
    err_en = 1'b0;

    // Auction never drops ready: timeout after TO wait cycles
    stub_mode = 1;
    push_loads(32'd7, 32'd8, 32'd9, 3'b100, 32'd1, 32'd2, 32'h99, 7);
    exp_run_q.push_back(16'd2);
    exp_res_q.push_back(mk_res(32'd0, 2'd2, NO_OP, 16 + 2));
    send_cmd(32'd7, 32'd8, 32'd9, 3'b100, 32'd1, 32'd2, 32'h99, 16'd2);
    wait_result("result_timeout");
    stub_mode = 0;

    // Reset two cycles into RUN: immediate return to reset values, no result
    push_loads(32'd21, 32'd22, 32'd23, 3'b011, 32'd24, 32'd25, 32'h26, 7);
    send_cmd(32'd21, 32'd22, 32'd23, 3'b011, 32'd24, 32'd25, 32'h26, 16'd10);
    wait_start();
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_c_start", c_start, 0);
    check("arst_cfg_ready", host.cfg_ready, 1);
    check("arst_c_op", c_op, NO_OP);
    check("arst_res_valid", host.res_valid, 0);
    check("arst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_ops_drained", exp_op_q.size(), 0);
    exp_op_q.delete();

    // Recovery round after reset
    stub_bid = 32'h1234;
    push_loads(32'hDEAD0001, 32'h7, 32'hFFFF_FFFF, 3'b101, 32'h10, 32'd2, 32'h5A, 7);
    push_ok(3, 32'h1234, 32'h5A);
    send_cmd(32'hDEAD0001, 32'h7, 32'hFFFF_FFFF, 3'b101, 32'h10, 32'd2, 32'h5A, 16'd3);
    wait_result("result_recovery");

    repeat (5) @(negedge clk);
    check("leftover_ops", exp_op_q.size(), 0);
    check("leftover_runs", exp_run_q.size(), 0);
    check("final_cfg_ready", host.cfg_ready, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
